// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM state encoding,
// RV32I load/store width codes and the access legality check.
package lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RMW_RD,
        S_RMW_WR,
        S_RESP,
        S_ERR
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // True when the width code is valid for the direction and the address is
    // naturally aligned for that width. Unsigned widths exist only for loads.
    function automatic logic access_ok(input logic       store,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            F3_BU:   ok = ~store;
            F3_HU:   ok = ~store & ~addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: load extract/extend and store merge for a
// little-endian 32-bit word. Lane n is bits [8n+7:8n]; halfword lane is offset[1].
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [15:0] wdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] rdata_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word_i[{offset_i, 3'b000} +: 8];
    assign half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];

    // Load path: pick the addressed lane and sign- or zero-extend it.
    // NOTE: every output of a combinational block gets a value on every path
    // (here via the default arm) so no latch is inferred.
    always_comb begin
        case (funct3_i)
            F3_B:    rdata_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   rdata_o = {24'h0, byte_sel};
            F3_H:    rdata_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   rdata_o = {16'h0, half_sel};
            default: rdata_o = word_i;
        endcase
    end

    // Store path: overwrite only the addressed lane(s) of the word read back.
    always_comb begin
        merged_o = word_i;
        case (funct3_i)
            F3_B:    merged_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
            F3_H:    merged_o[{offset_i[1], 4'b0000} +: 16] = wdata_i;
            default: merged_o = word_i;
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit on the word-only data-memory port. One request at a time;
// sub-word stores are done as read-modify-write, sub-word loads are extended.
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t        state_q, state_d;
    logic              store_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       word_q;
    logic [31:0]       rdata_q;
    logic              accept;
    logic [31:0]       load_data;
    logic [31:0]       merged_word;

    assign accept   = req_valid && req_ready;
    assign mem_addr = {addr_q[ADDR_W-1:2], 2'b00};

    lsu_align u_align (
        .word_i   (mem_rdata),
        .wdata_i  (wdata_q[15:0]),
        .offset_i (addr_q[1:0]),
        .funct3_i (funct3_q),
        .rdata_o  (load_data),
        .merged_o ()
    );

    lsu_align u_merge (
        .word_i   (word_q),
        .wdata_i  (wdata_q[15:0]),
        .offset_i (addr_q[1:0]),
        .funct3_i (funct3_q),
        .rdata_o  (),
        .merged_o (merged_word)
    );

    // State register; an asynchronous reset returns to IDLE and drops strobes at once.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: route a new request by legality, direction and width.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!access_ok(req_store, req_funct3, req_addr[1:0])) state_d = S_ERR;
                    else if (!req_store)                                  state_d = S_RD;
                    else if (req_funct3 == F3_W)                          state_d = S_WR;
                    else                                                  state_d = S_RMW_RD;
                end
            end
            S_RD:     state_d = S_RESP;
            S_WR:     state_d = S_RESP;
            S_RMW_RD: state_d = S_RMW_WR;
            S_RMW_WR: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            S_ERR:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state only; read and write strobes are mutually exclusive.
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        MemRead    = (state_q == S_RD) || (state_q == S_RMW_RD);
        MemWrite   = (state_q == S_WR) || (state_q == S_RMW_WR);
        resp_valid = (state_q == S_RESP) || (state_q == S_ERR);
        resp_err   = (state_q == S_ERR);
        resp_rdata = ((state_q == S_RESP) && !store_q) ? rdata_q : 32'h0;
        case (state_q)
            S_WR:     mem_wdata = wdata_q;
            S_RMW_WR: mem_wdata = merged_word;
            default:  mem_wdata = 32'h0;
        endcase
    end

    // Request capture, load-result latch and the word read back for RMW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            word_q   <= 32'h0;
            rdata_q  <= 32'h0;
        end else begin
            if (accept) begin
                store_q  <= req_store;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
            if (state_q == S_RD)     rdata_q <= load_data;
            if (state_q == S_RMW_RD) word_q  <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw with a small word-addressed memory model.
module tb_lsu_rmw;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    // NOTE: the model memory has no reset; the bench preloads the words it uses.
    logic [31:0] mem [16];

    lsu_rmw #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[5:2]];

    always @(posedge clk) begin
        if (MemWrite) mem[mem_addr[5:2]] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    // Present one request when the unit is ready; return #1 after the accepting edge.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {31'h0, req_ready}, 32'h1);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_wdata  = 32'hFFFF_FFFF;
        req_addr   = 32'hFFFF_FFFF;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
        issue(1'b0, f3, a, 32'h0);
        check({name, "_rd_strobe"}, {30'h0, MemRead, MemWrite}, 32'h2);
        check({name, "_addr"}, mem_addr, a & 32'hFFFF_FFFC);
        check({name, "_ready_low"}, {31'h0, req_ready}, 32'h0);
        next_cycle();
        check({name, "_resp"}, {29'h0, resp_valid, resp_err, MemRead}, 32'h4);
        check({name, "_data"}, resp_rdata, exp);
    endtask

    task automatic do_rmw(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_word);
        issue(1'b1, f3, a, wd);
        check({name, "_rd_strobe"}, {30'h0, MemRead, MemWrite}, 32'h2);
        next_cycle();
        check({name, "_wr_strobe"}, {30'h0, MemRead, MemWrite}, 32'h1);
        check({name, "_wdata"}, mem_wdata, exp_word);
        check({name, "_no_resp_yet"}, {31'h0, resp_valid}, 32'h0);
        next_cycle();
        check({name, "_resp"}, {30'h0, resp_valid, resp_err}, 32'h2);
        check({name, "_rdata_zero"}, resp_rdata, 32'h0);
    endtask

    task automatic do_err(input string name, input logic st, input logic [2:0] f3, input logic [31:0] a);
        issue(st, f3, a, 32'h5A5A_5A5A);
        check({name, "_resp"}, {29'h0, resp_valid, resp_err, 1'b0}, 32'h6);
        check({name, "_no_strobe"}, {30'h0, MemRead, MemWrite}, 32'h0);
        check({name, "_rdata_zero"}, resp_rdata, 32'h0);
        next_cycle();
        check({name, "_idle_after"}, {29'h0, req_ready, MemRead, MemWrite}, 32'h4);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[4]     = 32'h8899_AABB;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        check("rst_resp", {30'h0, resp_valid, resp_err}, 32'h0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_strobes", {30'h0, MemRead, MemWrite}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Loads from the word 0x8899AABB at 0x10.
        do_load("lw",  3'b010, 32'h10, 32'h8899_AABB);
        do_load("lb",  3'b000, 32'h13, 32'hFFFF_FF88);
        do_load("lbu", 3'b100, 32'h13, 32'h0000_0088);
        do_load("lh",  3'b001, 32'h12, 32'hFFFF_8899);
        do_load("lhu", 3'b101, 32'h10, 32'h0000_AABB);
        do_load("lb0", 3'b000, 32'h10, 32'hFFFF_FFBB);

        // Sub-word stores via read-modify-write.
        do_rmw("sb", 3'b000, 32'h11, 32'h0000_00CC, 32'h8899_CCBB);
        do_load("lw_after_sb", 3'b010, 32'h10, 32'h8899_CCBB);
        mem[4] = 32'h8899_AABB;
        do_rmw("sh", 3'b001, 32'h12, 32'h0000_1234, 32'h1234_AABB);
        do_load("lw_after_sh", 3'b010, 32'h10, 32'h1234_AABB);

        // Full-word store: a single write, response one cycle later.
        issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        check("sw_wr_strobe", {30'h0, MemRead, MemWrite}, 32'h1);
        check("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
        next_cycle();
        check("sw_resp", {29'h0, resp_valid, resp_err, MemWrite}, 32'h4);
        do_load("lw_after_sw", 3'b010, 32'h10, 32'hDEAD_BEEF);

        // Rejected accesses.
        do_err("lw_mis",  1'b0, 3'b010, 32'h11);
        do_err("sh_mis",  1'b1, 3'b001, 32'h13);
        do_err("st_f100", 1'b1, 3'b100, 32'h10);
        do_err("ld_f011", 1'b0, 3'b011, 32'h10);
        check("err_mem_untouched", mem[4], 32'hDEAD_BEEF);

        // Reset during the read phase of an SB aborts it without a response.
        issue(1'b1, 3'b000, 32'h11, 32'h0000_0055);
        check("abort_rd_strobe", {30'h0, MemRead, MemWrite}, 32'h2);
        rst_n = 1'b0;
        #1;
        check("abort_strobes_low", {30'h0, MemRead, MemWrite}, 32'h0);
        check("abort_idle", {30'h0, req_ready, resp_valid}, 32'h2);
        next_cycle();
        check("abort_no_write", {30'h0, MemWrite, resp_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            check("abort_no_resp", {30'h0, resp_valid, MemWrite}, 32'h0);
        end
        check("abort_ready", {31'h0, req_ready}, 32'h1);
        check("abort_mem_unchanged", mem[4], 32'hDEAD_BEEF);
        do_load("lw_after_abort", 3'b010, 32'h10, 32'hDEAD_BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
